// File: rtl/pc_fetch_pred.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_fetch_pred                                                 |
// | Brief    : IF-stage PC generator with BHT/BTB branch prediction.         |
// |            Define BPRED_EN to build the prediction tables.               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pc_fetch_pred #(
   parameter int          IDX_W    = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_mispredict,
   output logic [31:0] pc,
   output logic        ce,
   output logic        pred_taken,
   output logic [31:0] pred_target
);

   logic [31:0] pc_q, pc_d;
   logic        ce_q, ce_d;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] pc_seq;
   logic [29:0] upd_word;
   logic [29:0] tgt_word;

   // Word addresses only: the low two bits of incoming addresses are dropped.
   assign upd_word    = upd_pc[31:2];
   assign tgt_word    = upd_target[31:2];
   assign redirect    = upd_valid & upd_mispredict;
   assign redirect_pc = upd_taken ? {tgt_word, 2'b00} : {upd_word + 30'd1, 2'b00};
   assign pc_seq      = {pc_q[31:2] + 30'd1, 2'b00};

`ifdef BPRED_EN
   localparam int ENTRIES = 2**IDX_W;
   localparam int TAG_W   = 32 - IDX_W - 2;

   logic [1:0]       bht_q        [ENTRIES];
   logic [1:0]       bht_d        [ENTRIES];
   logic             btb_valid_q  [ENTRIES];
   logic             btb_valid_d  [ENTRIES];
   logic [TAG_W-1:0] btb_tag_q    [ENTRIES];
   logic [TAG_W-1:0] btb_tag_d    [ENTRIES];
   logic [29:0]      btb_target_q [ENTRIES];
   logic [29:0]      btb_target_d [ENTRIES];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             hit;
   logic             unused_bits;

   assign rd_idx      = pc_q[IDX_W+1:2];
   assign wr_idx      = upd_pc[IDX_W+1:2];
   assign hit         = btb_valid_q[rd_idx] & (btb_tag_q[rd_idx] == pc_q[31:IDX_W+2]);
   assign pred_taken  = ce_q & hit & bht_q[rd_idx][1];
   assign pred_target = {btb_target_q[rd_idx], 2'b00};
   assign unused_bits = ^{stall[5:1], upd_pc[1:0], upd_target[1:0]};

   always_comb begin
      bht_d        = bht_q;
      btb_valid_d  = btb_valid_q;
      btb_tag_d    = btb_tag_q;
      btb_target_d = btb_target_q;
      if (ce_q && upd_valid) begin
         if (upd_taken) begin
            if (bht_q[wr_idx] != 2'b11) begin
               bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
            end
            btb_valid_d[wr_idx]  = 1'b1;
            btb_tag_d[wr_idx]    = upd_pc[31:IDX_W+2];
            btb_target_d[wr_idx] = tgt_word;
         end else if (bht_q[wr_idx] != 2'b00) begin
            bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
         end
      end
   end

   // Tables come up weak not-taken with every BTB entry invalid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht_q[i]        <= 2'b01;
            btb_valid_q[i]  <= 1'b0;
            btb_tag_q[i]    <= '0;
            btb_target_q[i] <= '0;
         end
      end else begin
         bht_q        <= bht_d;
         btb_valid_q  <= btb_valid_d;
         btb_tag_q    <= btb_tag_d;
         btb_target_q <= btb_target_d;
      end
   end
`else
   logic unused_bits;

   assign pred_taken  = 1'b0;
   assign pred_target = 32'h0000_0000;
   assign unused_bits = ^{stall[5:1], upd_pc[1:0], upd_target[1:0]};
`endif

   always_comb begin
      ce_d = 1'b1;
      pc_d = pc_q;
      if (!ce_q) begin
         pc_d = RESET_PC;
      end else if (redirect) begin
         pc_d = redirect_pc;
      end else if (stall[0]) begin
         pc_d = pc_q;
      end else if (pred_taken) begin
         pc_d = pred_target;
      end else begin
         pc_d = pc_seq;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
         ce_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         ce_q <= ce_d;
      end
   end

   assign pc = pc_q;
   assign ce = ce_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_pred.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pc_fetch_pred                                              |
// | Brief    : Self-checking bench for pc_fetch_pred (either BPRED_EN build).|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_pc_fetch_pred;

   localparam int NSLOT = 64;
`ifdef BPRED_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispredict;
   logic [31:0] pc;
   logic        ce;
   logic        pred_taken;
   logic [31:0] pred_target;

   int n_cmp = 0;
   int n_err = 0;

   pc_fetch_pred #(.IDX_W(6), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispredict(upd_mispredict),
      .pc(pc), .ce(ce), .pred_taken(pred_taken), .pred_target(pred_target)
   );

   always #5 clk = ~clk;

   // Reference model: counters per slot, plus the last taken branch that owns the slot.
   logic [31:0] m_pc;
   logic        m_ce;
   int          m_cnt [NSLOT];
   bit          m_val [NSLOT];
   logic [31:0] m_own [NSLOT];
   logic [31:0] m_tgt [NSLOT];

   function automatic int slot(input logic [31:0] a);
      return int'((a >> 2) % NSLOT);
   endfunction

   function automatic bit exp_pred();
      if (!BP || !m_ce) return 1'b0;
      return m_val[slot(m_pc)] && (m_own[slot(m_pc)] == m_pc) && (m_cnt[slot(m_pc)] >= 2);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pc <= 32'h0;
         m_ce <= 1'b0;
         for (int i = 0; i < NSLOT; i++) begin
            m_cnt[i] <= 1;
            m_val[i] <= 1'b0;
         end
      end else if (!m_ce) begin
         m_ce <= 1'b1;
      end else begin
         if (upd_valid && upd_mispredict)
            m_pc <= upd_taken ? (upd_target & ~32'h3) : ((upd_pc & ~32'h3) + 32'd4);
         else if (stall[0])
            m_pc <= m_pc;
         else if (exp_pred())
            m_pc <= m_tgt[slot(m_pc)];
         else
            m_pc <= m_pc + 32'd4;
         if (upd_valid) begin
            if (upd_taken) begin
               m_cnt[slot(upd_pc)] <= (m_cnt[slot(upd_pc)] == 3) ? 3 : m_cnt[slot(upd_pc)] + 1;
               m_val[slot(upd_pc)] <= 1'b1;
               m_own[slot(upd_pc)] <= upd_pc & ~32'h3;
               m_tgt[slot(upd_pc)] <= upd_target & ~32'h3;
            end else begin
               m_cnt[slot(upd_pc)] <= (m_cnt[slot(upd_pc)] == 0) ? 0 : m_cnt[slot(upd_pc)] - 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("m_pc", pc, m_pc);
      check("m_ce", {31'd0, ce}, {31'd0, m_ce});
      check("m_pred", {31'd0, pred_taken}, {31'd0, exp_pred()});
      if (!BP)
         check("m_tgt0", pred_target, 32'h0);
      else if (exp_pred())
         check("m_tgt", pred_target, m_tgt[slot(m_pc)]);
   end

   task automatic idle();
      stall = 6'd0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      upd_target = '0; upd_mispredict = 1'b0;
   endtask

   task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tg, input logic mis);
      upd_valid = 1'b1; upd_pc = a; upd_taken = t; upd_target = tg; upd_mispredict = mis;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      idle();
      repeat (3) @(negedge clk);
      check("reset_pc", pc, 32'h0);
      check("reset_ce", {31'd0, ce}, 32'd0);
      check("reset_pred", {31'd0, pred_taken}, 32'd0);
      rst = 1'b1;
      @(negedge clk); check("start_ce", {31'd0, ce}, 32'd1); check("start_pc", pc, 32'h0);
      @(negedge clk); check("seq_4", pc, 32'h4);
      @(negedge clk); check("seq_8", pc, 32'h8);
      stall = 6'b000011;
      @(negedge clk); check("stall_1", pc, 32'h8);
      @(negedge clk); check("stall_2", pc, 32'h8);
      stall = 6'd0;
      @(negedge clk); check("after_stall", pc, 32'hC);

      upd(32'h10, 1'b1, 32'h40, 1'b0);
      @(negedge clk); idle();
      check("fetch_10", pc, 32'h10);
      check("pred_10", {31'd0, pred_taken}, {31'd0, BP});
      if (BP) check("tgt_10", pred_target, 32'h40);
      @(negedge clk); check("follow", pc, BP ? 32'h40 : 32'h14);
      @(negedge clk); check("pc_44", pc, BP ? 32'h44 : 32'h18);

      upd(32'h10, 1'b0, 32'h40, 1'b1); stall = 6'b000001;
      @(negedge clk); idle();
      check("redirect_stall", pc, 32'h14);
      upd(32'hC, 1'b0, 32'h0, 1'b1);
      @(negedge clk); idle();
      check("redir_10", pc, 32'h10);
      check("pred_weak", {31'd0, pred_taken}, 32'd0);

      repeat (4) begin
         upd(32'h10, 1'b1, 32'h40, 1'b0);
         @(negedge clk);
      end
      upd(32'h110, 1'b1, 32'h80, 1'b0);
      @(negedge clk);
      upd(32'hC, 1'b0, 32'h0, 1'b1);
      @(negedge clk); idle();
      check("alias_pc", pc, 32'h10);
      check("alias_miss", {31'd0, pred_taken}, 32'd0);
      upd(32'h10C, 1'b0, 32'h0, 1'b1);
      @(negedge clk); idle();
      check("owner_pc", pc, 32'h110);
      check("owner_pred", {31'd0, pred_taken}, {31'd0, BP});
      if (BP) check("owner_tgt", pred_target, 32'h80);
      @(negedge clk); check("owner_follow", pc, BP ? 32'h80 : 32'h114);

      upd(32'h200, 1'b1, 32'hFFFF_FFFF, 1'b1);
      @(negedge clk); idle();
      check("wrap_top", pc, 32'hFFFF_FFFC);
      @(negedge clk); check("wrap_zero", pc, 32'h0);
      @(negedge clk); check("wrap_4", pc, 32'h4);

      #2 rst = 1'b0;
      #1 check("midrst_pc", pc, 32'h0);
      check("midrst_ce", {31'd0, ce}, 32'd0);
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_pc", pc, 32'h10);
      check("post_rst_pred", {31'd0, pred_taken}, 32'd0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
